// File: rtl/wb_stage_reg.sv
// rtl/wb_stage_reg.sv - registered MEM/WB stage with load alignment, writeback select and retire counter
module wb_stage_reg #(
  parameter int DATA_W           = 32,
  parameter int REG_AW           = 5,
  parameter int ZERO_REG_PROTECT = 1,
  parameter int CNT_W            = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] MemOp,
  input  logic [DATA_W-1:0] ResultRType,
  input  logic [DATA_W-1:0] LinkAddr,
  input  logic [1:0]        ByteOff,
  input  logic [2:0]        LdType,
  input  logic [REG_AW-1:0] DestReg,
  input  logic [2:0]        WB,
  output logic [DATA_W-1:0] Result,
  output logic [REG_AW-1:0] DestRegReg,
  output logic              RegWrite,
  output logic              wb_valid,
  output logic              misalign,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wb_data;
  logic              is_half;
  logic              is_word;
  logic              mis_now;
  logic              wen_q;
  logic              fresh;

  always_comb begin
    case (ByteOff)
      2'd0:    byte_lane = MemOp[7:0];
      2'd1:    byte_lane = MemOp[15:8];
      2'd2:    byte_lane = MemOp[23:16];
      default: byte_lane = MemOp[31:24];
    endcase
    half_lane = ByteOff[1] ? MemOp[31:16] : MemOp[15:0];

    // Unlisted LdType encodings behave as LW, including for misalignment.
    case (LdType)
      3'b001:  load_data = DATA_W'($signed(byte_lane));
      3'b010:  load_data = DATA_W'(byte_lane);
      3'b011:  load_data = DATA_W'($signed(half_lane));
      3'b100:  load_data = DATA_W'(half_lane);
      default: load_data = DATA_W'($signed(MemOp[31:0]));
    endcase

    is_half = (LdType == 3'b011) || (LdType == 3'b100);
    is_word = (LdType == 3'b000) || (LdType > 3'b100);
    mis_now = (WB[1:0] == 2'b01) &&
              ((is_half && ByteOff[0]) || (is_word && (ByteOff != 2'b00)));

    case (WB[1:0])
      2'b01:   wb_data = load_data;
      2'b10:   wb_data = LinkAddr;
      default: wb_data = ResultRType;
    endcase
  end

  // fresh marks the first output cycle, so a stalled instruction writes only once.
  assign RegWrite = wb_valid & fresh & wen_q & ~misalign &
                    ~((ZERO_REG_PROTECT != 0) && (DestRegReg == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Result      <= '0;
      DestRegReg  <= '0;
      wen_q       <= 1'b0;
      misalign    <= 1'b0;
      wb_valid    <= 1'b0;
      fresh       <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (RegWrite)
        retired_cnt <= retired_cnt + CNT_W'(1);
      if (flush) begin
        wb_valid <= 1'b0;
        fresh    <= 1'b0;
      end else if (stall) begin
        fresh <= 1'b0;
      end else begin
        Result     <= wb_data;
        DestRegReg <= DestReg;
        wen_q      <= WB[2];
        misalign   <= mis_now;
        wb_valid   <= in_valid;
        fresh      <= in_valid;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_reg.sv
// tb/tb_wb_stage_reg.sv - randomized and directed bench for wb_stage_reg against a behavioural model
module tb_wb_stage_reg;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush;
  logic [31:0] MemOp, ResultRType, LinkAddr;
  logic [1:0]  ByteOff;
  logic [2:0]  LdType, WB;
  logic [4:0]  DestReg;
  logic [31:0] Result;
  logic [4:0]  DestRegReg;
  logic        RegWrite, wb_valid, misalign;
  logic [CW-1:0] retired_cnt;

  int n_vec = 0;
  int n_err = 0;

  // model of the stage contents
  logic [31:0] m_result;
  logic [4:0]  m_dest;
  logic        m_wen, m_mis, m_valid, m_fresh;
  int          m_cnt;

  wb_stage_reg #(.DATA_W(32), .REG_AW(5), .ZERO_REG_PROTECT(1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .MemOp(MemOp), .ResultRType(ResultRType), .LinkAddr(LinkAddr), .ByteOff(ByteOff),
    .LdType(LdType), .DestReg(DestReg), .WB(WB), .Result(Result), .DestRegReg(DestRegReg),
    .RegWrite(RegWrite), .wb_valid(wb_valid), .misalign(misalign), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_load(logic [31:0] mem, logic [2:0] ld, logic [1:0] off);
    logic [31:0] b, h;
    b = (mem >> (8 * off)) & 32'hFF;
    h = (mem >> (16 * off[1])) & 32'hFFFF;
    case (ld)
      3'd1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd2: return b;
      3'd3: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4: return h;
      default: return mem;
    endcase
  endfunction

  function automatic logic exp_mis(logic [1:0] src, logic [2:0] ld, logic [1:0] off);
    if (src != 2'd1) return 1'b0;
    if (ld == 3'd3 || ld == 3'd4) return off[0];
    if (ld == 3'd1 || ld == 3'd2) return 1'b0;
    return off != 2'd0;
  endfunction

  function automatic logic exp_rw();
    return m_valid && m_fresh && m_wen && !m_mis && (m_dest != 5'd0);
  endfunction

  task automatic model_reset();
    m_result = 0; m_dest = 0; m_wen = 0; m_mis = 0; m_valid = 0; m_fresh = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (exp_rw()) m_cnt = (m_cnt + 1) % (1 << CW);
    if (flush) begin
      m_valid = 0; m_fresh = 0;
    end else if (stall) begin
      m_fresh = 0;
    end else begin
      case (WB[1:0])
        2'd1: m_result = exp_load(MemOp, LdType, ByteOff);
        2'd2: m_result = LinkAddr;
        default: m_result = ResultRType;
      endcase
      m_dest = DestReg; m_wen = WB[2]; m_mis = exp_mis(WB[1:0], LdType, ByteOff);
      m_valid = in_valid; m_fresh = in_valid;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [2:0] wbv, input logic [4:0] dst,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] ld,
                        input logic [1:0] off, input logic [31:0] lnk);
    in_valid = iv; WB = wbv; DestReg = dst; ResultRType = alu; MemOp = mem;
    LdType = ld; ByteOff = off; LinkAddr = lnk; stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    set_in(0, 3'b000, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({Result, DestRegReg, RegWrite, wb_valid, misalign, retired_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset: got Result=%h Dest=%0d RW=%b V=%b M=%b cnt=%0d, want all 0",
               Result, DestRegReg, RegWrite, wb_valid, misalign, retired_cnt);
    end
    reset = 1;
    #3;
  endtask

  task automatic test_alu();
    set_in(1, 3'b100, 5, 32'h1234_5678, 0, 0, 0, 0);
    tick();
    n_vec++;
    if (Result !== 32'h1234_5678 || DestRegReg !== 5'd5 || RegWrite !== 1'b1) begin
      n_err++;
      $display("FAIL alu: got Result=%h Dest=%0d RW=%b, want 12345678 5 1", Result, DestRegReg, RegWrite);
    end
    set_in(0, 3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++;
    if (retired_cnt !== CW'(1) || RegWrite !== 1'b0) begin
      n_err++;
      $display("FAIL alu_cnt: got cnt=%0d RW=%b, want 1 0", retired_cnt, RegWrite);
    end
  endtask

  task automatic test_load();
    logic [2:0]  lds  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [1:0]  offs [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] want [4] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      set_in(1, 3'b101, 7, 32'hDEAD_BEEF, 32'h80FF_7F01, lds[i], offs[i], 0);
      tick();
      n_vec++;
      if (Result !== want[i] || RegWrite !== 1'b1 || misalign !== 1'b0) begin
        n_err++;
        $display("FAIL load%0d: got Result=%h RW=%b M=%b, want %h 1 0", i, Result, RegWrite, misalign, want[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int c0;
    set_in(0, 3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    c0 = m_cnt;
    set_in(1, 3'b101, 9, 0, 32'h80FF_7F01, 3'd3, 2'd1, 0);
    tick();
    n_vec++;
    if (misalign !== 1'b1 || RegWrite !== 1'b0) begin
      n_err++;
      $display("FAIL misalign: got M=%b RW=%b, want 1 0", misalign, RegWrite);
    end
    set_in(0, 3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++;
    if (retired_cnt !== CW'(c0)) begin
      n_err++;
      $display("FAIL misalign_cnt: got %0d, want %0d", retired_cnt, c0);
    end
  endtask

  task automatic test_link_zero();
    set_in(1, 3'b110, 31, 32'h1111_1111, 0, 0, 0, 32'h0040_0008);
    tick();
    n_vec++;
    if (Result !== 32'h0040_0008 || RegWrite !== 1'b1) begin
      n_err++;
      $display("FAIL link: got Result=%h RW=%b, want 00400008 1", Result, RegWrite);
    end
    DestReg = 0;
    tick();
    n_vec++;
    if (Result !== 32'h0040_0008 || RegWrite !== 1'b0) begin
      n_err++;
      $display("FAIL zero_reg: got Result=%h RW=%b, want 00400008 0", Result, RegWrite);
    end
  endtask

  task automatic test_stall_flush();
    int c0, writes;
    set_in(0, 3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    c0 = m_cnt;
    writes = 0;
    set_in(1, 3'b100, 12, 32'hCAFE_0001, 0, 0, 0, 0);
    tick();
    writes += RegWrite;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 3'b100, 13, 32'h5555_AAAA, 0, 0, 0, 0);
      stall = 1;
      tick();
      writes += RegWrite;
      n_vec++;
      if (Result !== 32'hCAFE_0001 || wb_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold%0d: got Result=%h V=%b, want cafe0001 1", i, Result, wb_valid);
      end
    end
    n_vec++;
    if (writes != 1 || retired_cnt !== CW'((c0 + 1) % (1 << CW))) begin
      n_err++;
      $display("FAIL stall_once: got writes=%0d cnt=%0d, want 1 %0d", writes, retired_cnt, (c0 + 1) % (1 << CW));
    end
    flush = 1;
    stall = 1;
    tick();
    n_vec++;
    if (wb_valid !== 1'b0 || RegWrite !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall: got V=%b RW=%b, want 0 0", wb_valid, RegWrite);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      MemOp = $urandom; ResultRType = $urandom; LinkAddr = $urandom;
      ByteOff = 2'($urandom); LdType = 3'($urandom); WB = 3'($urandom);
      DestReg = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      tick();
      n_vec++;
      if (Result !== m_result || DestRegReg !== m_dest || RegWrite !== exp_rw() ||
          wb_valid !== m_valid || misalign !== m_mis || retired_cnt !== CW'(m_cnt)) begin
        n_err++;
        $display("FAIL random%0d: got R=%h D=%0d RW=%b V=%b M=%b C=%0d, want R=%h D=%0d RW=%b V=%b M=%b C=%0d",
                 i, Result, DestRegReg, RegWrite, wb_valid, misalign, retired_cnt,
                 m_result, m_dest, exp_rw(), m_valid, m_mis, m_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 3'b100, 3, 32'h0BAD_F00D, 0, 0, 0, 0);
    tick();
    stall = 1;
    tick();
    #2;
    reset = 0;
    model_reset();
    #1;
    n_vec++;
    if ({Result, DestRegReg, RegWrite, wb_valid, misalign, retired_cnt} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got Result=%h V=%b RW=%b cnt=%0d, want all 0", Result, wb_valid, RegWrite, retired_cnt);
    end
    #2;
    reset = 1;
    tick();
    n_vec++;
    if (RegWrite !== 1'b0 || wb_valid !== 1'b0 || retired_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_discard: got RW=%b V=%b cnt=%0d, want 0 0 0", RegWrite, wb_valid, retired_cnt);
    end
  endtask

  task automatic test_back_to_back_wrap();
    set_in(1, 3'b100, 4, 32'h0000_0042, 0, 0, 0, 0);
    for (int i = 0; i < (1 << CW); i++) begin
      ResultRType = i;
      tick();
    end
    n_vec++;
    if (retired_cnt !== CW'((1 << CW) - 1) || RegWrite !== 1'b1) begin
      n_err++;
      $display("FAIL preload: got cnt=%0d RW=%b, want %0d 1", retired_cnt, RegWrite, (1 << CW) - 1);
    end
    in_valid = 0;
    tick();
    n_vec++;
    if (retired_cnt !== '0 || retired_cnt !== CW'(m_cnt)) begin
      n_err++;
      $display("FAIL wrap: got cnt=%0d, want 0", retired_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_misalign();
    test_link_zero();
    test_stall_flush();
    test_random();
    test_async_reset();
    test_back_to_back_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
